// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory controller.
//   - dmtype encodings (W, H, HU, B, BU; any other code is handled as W)
//   - FSM state enum for mem_access_unit
//   - byte-enable / store-data generation and misalignment helper functions
package mem_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Byte enables for the addressed lane(s); low address bits that are
  // illegal for the access size are simply ignored (forced alignment).
  function automatic logic [3:0] gen_be(input logic [2:0] dmtype, input logic [1:0] a);
    case (dmtype)
      DM_B, DM_BU: gen_be = 4'b0001 << a;
      DM_H, DM_HU: gen_be = 4'b0011 << {a[1], 1'b0};
      default:     gen_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the memory only needs the BE.
  function automatic logic [31:0] gen_wdata(input logic [2:0] dmtype, input logic [31:0] rd2);
    case (dmtype)
      DM_B, DM_BU: gen_wdata = {4{rd2[7:0]}};
      DM_H, DM_HU: gen_wdata = {2{rd2[15:0]}};
      default:     gen_wdata = rd2;
    endcase
  endfunction

  // Low address bits illegal for the access size (undefined types count as W).
  function automatic logic is_misaligned(input logic [2:0] dmtype, input logic [1:0] a);
    case (dmtype)
      DM_B, DM_BU: is_misaligned = 1'b0;
      DM_H, DM_HU: is_misaligned = a[0];
      default:     is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
//   rdata   in  32  word returned by the data memory
//   addr_lo in  2   low byte-address bits of the access
//   dmtype  in  3   access type (mem_pkg encodings; unknown codes act as W)
//   data    out 32  aligned and extended load result
module load_align import mem_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dmtype,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword lanes, then extend per access type.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (dmtype)
      DM_B:    data = {{24{byte_s[7]}}, byte_s};
      DM_BU:   data = {24'h00_0000, byte_s};
      DM_H:    data = {{16{half_s[15]}}, half_s};
      DM_HU:   data = {16'h0000, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller between EX/MEM and MEM/WB.
// Converts EX/MEM load/store fields into a req/ack transaction, aligns load
// data and stalls the pipeline until the access completes (IDLE->BUSY->DONE).
//   Parameter TIMEOUT_CYCLES: BUSY cycles without dm_ack before bus_err abort.
//   Inputs : clk, rst (sync, active-high), ex_mem_valid, ex_mem_mem_read,
//            ex_mem_mem_write, ex_mem_dmtype[2:0], ex_mem_aluout[31:0],
//            ex_mem_rd2[31:0], dm_ack, dm_rdata[31:0]
//   Outputs: dm_req, dm_we, dm_addr[31:0], dm_be[3:0], dm_wdata[31:0],
//            mem_read_data[31:0], mem_stall, bus_err, misalign_exc
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses
// (no request, misalign_exc pulse); otherwise low bits are forced aligned and
// misalign_exc stays 0.
module mem_access_unit import mem_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_dmtype,
  input  logic [31:0] ex_mem_aluout,
  input  logic [31:0] ex_mem_rd2,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misalign_exc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value on the last BUSY cycle allowed before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       dmtype_r;
  logic [1:0]       addr_lo_r;
  logic             access_s;
  logic             trap_s;
  logic [31:0]      aligned_s;

  // A read+write combination is a store: dm_we follows mem_write alone.
  assign access_s = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s = access_s & is_misaligned(ex_mem_dmtype, ex_mem_aluout[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Stall asserts in the same cycle the access is first seen, so the
  // instruction is frozen on EX/MEM; DONE releases it so MEM/WB captures.
  assign mem_stall = ~rst & (((state_r == ST_IDLE) & access_s) | (state_r == ST_BUSY));

  load_align u_load_align (
    .rdata   (dm_rdata),
    .addr_lo (addr_lo_r),
    .dmtype  (dmtype_r),
    .data    (aligned_s)
  );

  // Access FSM with all memory-port and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      dmtype_r      <= 3'b000;
      addr_lo_r     <= 2'b00;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= 32'h0000_0000;
      dm_be         <= 4'b0000;
      dm_wdata      <= 32'h0000_0000;
      mem_read_data <= 32'h0000_0000;
      bus_err       <= 1'b0;
      misalign_exc  <= 1'b0;
    end else begin
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (access_s && trap_s) begin
            // No request is issued; the store is suppressed.
            dm_we         <= 1'b0;
            mem_read_data <= 32'h0000_0000;
            misalign_exc  <= 1'b1;
            state_r       <= ST_DONE;
          end else if (access_s) begin
            dm_addr   <= {ex_mem_aluout[31:2], 2'b00};
            dm_be     <= gen_be(ex_mem_dmtype, ex_mem_aluout[1:0]);
            dm_wdata  <= gen_wdata(ex_mem_dmtype, ex_mem_rd2);
            dm_we     <= ex_mem_mem_write;
            dmtype_r  <= ex_mem_dmtype;
            addr_lo_r <= ex_mem_aluout[1:0];
            cnt_r     <= '0;
            dm_req    <= 1'b1;
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (dm_ack) begin
            mem_read_data <= dm_we ? 32'h0000_0000 : aligned_s;
            dm_req        <= 1'b0;
            state_r       <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            mem_read_data <= 32'h0000_0000;
            bus_err       <= 1'b1;
            dm_req        <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        // The instruction still on EX/MEM has completed; never reissue it.
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          dm_req  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit.
// A transaction-level model turns each EX/MEM instruction plus the chosen
// memory latency into the expected per-cycle outputs; one negedge process
// compares the DUT against that queue. Directed cases pin the model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_dmtype;
  logic [31:0] ex_mem_aluout, ex_mem_rd2;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, mem_read_data;
  logic [3:0]  dm_be;
  logic        mem_stall, bus_err, misalign_exc;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_dmtype(ex_mem_dmtype),
    .ex_mem_aluout(ex_mem_aluout), .ex_mem_rd2(ex_mem_rd2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall),
    .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  typedef struct {
    bit          stall, req, berr, mexc, chk_dm, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_seen = 0;
  logic [31:0] last_rd = 32'h0;
  int          cur_lat = 1000;
  logic [31:0] cur_rdata = 32'h0;
  bit          force_ack = 1'b0;
  int          req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (arithmetic on the access rules) ----
  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    if (t == 3'd3 || t == 3'd4) return 4'(1 << a[1:0]);
    if (t == 3'd1 || t == 3'd2) return 4'(3 << (a[1:0] & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
    if (t == 3'd3 || t == 3'd4) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (t == 3'd1 || t == 3'd2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * int'(a[1:0]));
    h = w >> (16 * int'(a[1]));
    case (t)
      3'd3:    return 32'($signed(b[7:0]));
      3'd4:    return {24'h0, b[7:0]};
      3'd1:    return 32'($signed(h[15:0]));
      3'd2:    return {16'h0, h[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit m_trap(input logic [2:0] t, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    if (t == 3'd1 || t == 3'd2) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk(bit stall, bit req, bit berr, bit mexc, bit chk_dm, bit we,
                              logic [31:0] addr, logic [3:0] be, logic [31:0] wd, logic [31:0] rd);
    exp_t e;
    e.stall = stall; e.req = req; e.berr = berr; e.mexc = mexc; e.chk_dm = chk_dm;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wd; e.rd = rd;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (expq.size() > 0) begin : cmp
      exp_t e;
      e = expq.pop_front();
      if (mem_stall === 1'b1) stall_seen++;
      check("mem_stall", 32'(mem_stall), 32'(e.stall));
      check("dm_req", 32'(dm_req), 32'(e.req));
      check("bus_err", 32'(bus_err), 32'(e.berr));
      check("misalign_exc", 32'(misalign_exc), 32'(e.mexc));
      check("mem_read_data", mem_read_data, e.rd);
      if (e.chk_dm) begin
        check("dm_addr", dm_addr, e.addr);
        check("dm_be", 32'(dm_be), 32'(e.be));
        check("dm_wdata", dm_wdata, e.wdata);
        check("dm_we", 32'(dm_we), 32'(e.we));
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        dm_ack = 1'b1;
        dm_rdata = $urandom;
      end else if (dm_req && req_cnt == cur_lat) begin
        dm_ack = 1'b1;
        dm_rdata = cur_rdata;
        req_cnt++;
      end else begin
        dm_ack = 1'b0;
        dm_rdata = $urandom;
        if (dm_req) req_cnt++;
        else req_cnt = 0;
      end
    end
  end

  // Drive one EX/MEM instruction (called at posedge+1), queue its expected
  // per-cycle outputs and wait until it has left the MEM stage.
  task automatic run_op(input bit v, input bit rd, input bit wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input int lat,
                        input logic [31:0] rdat);
    bit access, tmo;
    int nb, ncyc;
    logic [31:0] aw;
    ex_mem_valid = v; ex_mem_mem_read = rd; ex_mem_mem_write = wr;
    ex_mem_dmtype = t; ex_mem_aluout = a; ex_mem_rd2 = d;
    cur_lat = lat; cur_rdata = rdat;
    access = v && (rd || wr);
    aw = {a[31:2], 2'b00};
    if (!access) begin
      expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, last_rd));
      ncyc = 1;
    end else if (m_trap(t, a)) begin
      expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, last_rd));
      last_rd = 32'h0;
      expq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, last_rd));
      ncyc = 2;
    end else begin
      tmo = (lat >= TO);
      nb = tmo ? TO : lat + 1;
      expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, last_rd));
      repeat (nb) expq.push_back(mk(1, 1, 0, 0, 1, wr, aw, m_be(t, a), m_wdata(t, d), last_rd));
      last_rd = (tmo || wr) ? 32'h0 : m_load(t, a, rdat);
      expq.push_back(mk(0, 0, tmo, 0, 1, wr, aw, m_be(t, a), m_wdata(t, d), last_rd));
      ncyc = nb + 2;
    end
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  // Reset asserted while BUSY, followed by a stray ack that must be ignored.
  task automatic reset_in_busy();
    ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
    ex_mem_dmtype = 3'd0; ex_mem_aluout = 32'h0000_5004; ex_mem_rd2 = 32'h0;
    cur_lat = 1000;
    expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, last_rd));
    @(posedge clk); #1;
    expq.push_back(mk(1, 1, 0, 0, 1, 0, 32'h5004, 4'hF, 32'h0, last_rd));
    @(posedge clk); #1;
    rst = 1'b1; ex_mem_valid = 1'b0;
    expq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h5004, 4'hF, 32'h0, last_rd));
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b1;
    last_rd = 32'h0;
    expq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, last_rd));
    @(posedge clk); #1;
    force_ack = 1'b0;
    expq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, last_rd));
    @(posedge clk); #1;
  endtask

  initial begin : main
    int s0;
    logic [31:0] r;
    rst = 1'b1;
    ex_mem_valid = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    ex_mem_dmtype = 3'd0; ex_mem_aluout = 32'h0; ex_mem_rd2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    expq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model with hand-computed values.
    check("model_be_lb", 32'(m_be(3'd3, 32'h1003)), 32'h8);
    check("model_load_lb", m_load(3'd3, 32'h1003, 32'h80AA_BBCC), 32'hFFFF_FF80);
    check("model_be_sh", 32'(m_be(3'd1, 32'h2002)), 32'hC);
    check("model_wdata_sh", m_wdata(3'd1, 32'h1234_5678), 32'h5678_5678);
    check("model_load_hu", m_load(3'd2, 32'h2, 32'h80AA_BBCC), 32'h0000_80AA);

    // LB at 0x1003, ack in first BUSY cycle.
    s0 = stall_seen;
    run_op(1, 1, 0, 3'd3, 32'h1003, 32'h0, 0, 32'h80AA_BBCC);
    check("lb_result", mem_read_data, 32'hFFFF_FF80);
    check("lb_stall_cycles", 32'(stall_seen - s0), 32'd2);

    // SH at 0x2002.
    run_op(1, 0, 1, 3'd1, 32'h2002, 32'h1234_5678, 1, 32'hDEAD_BEEF);
    check("sh_addr", dm_addr, 32'h0000_2000);
    check("sh_be", 32'(dm_be), 32'hC);
    check("sh_wdata", dm_wdata, 32'h5678_5678);
    check("sh_we", 32'(dm_we), 32'd1);
    check("sh_result", mem_read_data, 32'h0);

    // LW with 3 wait cycles.
    r = $urandom;
    s0 = stall_seen;
    run_op(1, 1, 0, 3'd0, 32'h0000_4000, 32'h0, 3, r);
    check("lw_wait_stall_cycles", 32'(stall_seen - s0), 32'd5);
    check("lw_wait_result", mem_read_data, r);

    // No ack: timeout after TO BUSY cycles.
    s0 = stall_seen;
    run_op(1, 1, 0, 3'd0, 32'h0000_4100, 32'h0, 1000, 32'h1111_2222);
    check("timeout_stall_cycles", 32'(stall_seen - s0), 32'(TO + 1));
    check("timeout_result", mem_read_data, 32'h0);

    // Reset in BUSY then a late ack.
    reset_in_busy();
    check("post_reset_req", 32'(dm_req), 32'd0);
    check("post_reset_result", mem_read_data, 32'h0);

    // LW at 0x3001.
    s0 = stall_seen;
    run_op(1, 1, 0, 3'd0, 32'h0000_3001, 32'h0, 0, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign_stall_cycles", 32'(stall_seen - s0), 32'd1);
    check("misalign_result", mem_read_data, 32'h0);
`else
    check("forced_align_addr", dm_addr, 32'h0000_3000);
    check("forced_align_result", mem_read_data, 32'hCAFE_F00D);
    check("forced_align_stall_cycles", 32'(stall_seen - s0), 32'd2);
`endif

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      run_op(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
             3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom);
    end

    ex_mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
